// File: rtl/alu_exec.sv
// alu_exec: 32-bit integer execute unit. Shifts run one bit per cycle in a
// small FSM; every other operation completes in a single cycle.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        illegal
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  // shift direction / fill kind held while iterating
  localparam logic [1:0] DIR_SLL = 2'd0;
  localparam logic [1:0] DIR_SRL = 2'd1;
  localparam logic [1:0] DIR_SRA = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_result;
  logic        r_illegal;
  logic [31:0] r_work;
  logic [5:0]  r_cnt;
  logic [1:0]  r_dir;
  logic        r_fill;

  logic        w_accept;
  logic [31:0] w_opb;
  logic [4:0]  w_shamt;
  logic        w_is_shift;
  logic [1:0]  w_dir;
  logic [31:0] w_alu;
  logic        w_ill;
  logic [31:0] w_step;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign illegal   = r_illegal;
  assign w_accept  = in_valid && in_ready;

  // register ops take rs2, immediate ops (and illegal codes, harmlessly) take imm
  assign w_opb   = (alu_op <= 5'd9) ? rs2 : imm;
  assign w_shamt = w_opb[4:0];

  // single-cycle result; shifts report rs1 here, used only when shamt is zero
  always_comb begin
    w_alu      = 32'h0;
    w_ill      = 1'b0;
    w_is_shift = 1'b0;
    w_dir      = DIR_SLL;
    case (alu_op)
      5'd0, 5'd10:  w_alu = rs1 + w_opb;
      5'd1:         w_alu = rs1 - w_opb;
      5'd5, 5'd16:  w_alu = rs1 & w_opb;
      5'd6, 5'd18:  w_alu = rs1 | w_opb;
      5'd7, 5'd17:  w_alu = rs1 ^ w_opb;
      5'd8, 5'd14:  w_alu = {31'h0, $signed(rs1) < $signed(w_opb)};
      5'd9, 5'd15:  w_alu = {31'h0, rs1 < w_opb};
      5'd2, 5'd11: begin w_alu = rs1; w_is_shift = 1'b1; w_dir = DIR_SLL; end
      5'd3, 5'd12: begin w_alu = rs1; w_is_shift = 1'b1; w_dir = DIR_SRL; end
      5'd4, 5'd13: begin w_alu = rs1; w_is_shift = 1'b1; w_dir = DIR_SRA; end
      default:      w_ill = 1'b1;
    endcase
  end

  // one-bit shift step of the working register
  always_comb begin
    w_step = r_work;
    case (r_dir)
      DIR_SLL: w_step = {r_work[30:0], 1'b0};
      DIR_SRL: w_step = {1'b0, r_work[31:1]};
      DIR_SRA: w_step = {r_fill, r_work[31:1]};
      default: w_step = r_work;
    endcase
  end

  // control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_result  <= 32'h0;
      r_illegal <= 1'b0;
      r_work    <= 32'h0;
      r_cnt     <= 6'h0;
      r_dir     <= DIR_SLL;
      r_fill    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_work <= rs1;
          r_dir  <= w_dir;
          r_fill <= rs1[31];
          r_cnt  <= {1'b0, w_shamt};
          if (w_is_shift && (w_shamt != 5'd0)) begin
            r_state <= SHIFT;
          end else begin
            r_result  <= w_alu;
            r_illegal <= w_ill;
            r_state   <= DONE;
          end
        end
        SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result  <= w_step;
            r_illegal <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors with hand-computed results and latencies.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] rs1, rs2, imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_exec dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present an op, let it be accepted, scramble inputs, measure latency
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
    int lat;
    bit rdy_seen;
    alu_op = op; rs1 = a; rs2 = b; imm = im; in_valid = 1'b1;
    chk({tag, ".rdy"}, {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op = 5'($urandom); rs1 = $urandom; rs2 = $urandom; imm = $urandom;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".ill"}, {31'h0, illegal}, {31'h0, exp_ill});
    if (exp_lat > 1) chk({tag, ".busy"}, {31'h0, rdy_seen}, 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".idle"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 5'h0; rs1 = 32'h0; rs2 = 32'h0; imm = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ov",  {31'h0, out_valid}, 32'h0);
    chk("rst.res", result, 32'h0);
    chk("rst.ill", {31'h0, illegal}, 32'h0);
    rst = 1'b0;
    chk("rst.rdy", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    run_op("add",   5'd0,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1);
    run_op("sub",   5'd1,  32'h5, 32'h7, 32'h0, 32'hFFFFFFFE, 1'b0, 1);
    run_op("sll",   5'd2,  32'h1, 32'hFFFFFFE4, 32'h0, 32'h10, 1'b0, 5);
    run_op("srl",   5'd3,  32'h80000000, 32'h3, 32'h0, 32'h10000000, 1'b0, 4);
    run_op("sra",   5'd4,  32'h80000000, 32'h4, 32'h0, 32'hF8000000, 1'b0, 5);
    run_op("and",   5'd5,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h0, 32'h00F0F000, 1'b0, 1);
    run_op("or",    5'd6,  32'hF0000000, 32'h0000000F, 32'h0, 32'hF000000F, 1'b0, 1);
    run_op("xor",   5'd7,  32'hAAAA5555, 32'hFFFF0000, 32'h0, 32'h55555555, 1'b0, 1);
    run_op("slt",   5'd8,  32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 1'b0, 1);
    run_op("sltu",  5'd9,  32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    run_op("addi",  5'd10, 32'hA, 32'h12345, 32'hFFFFFFFF, 32'h9, 1'b0, 1);
    run_op("slli",  5'd11, 32'h3, 32'h5, 32'h21, 32'h6, 1'b0, 2);
    run_op("srli",  5'd12, 32'hFFFFFFFF, 32'h0, 32'h1C, 32'hF, 1'b0, 29);
    run_op("srai",  5'd13, 32'h80000000, 32'h0, 32'h1F, 32'hFFFFFFFF, 1'b0, 32);
    run_op("srai+", 5'd13, 32'h7FFFFFFF, 32'h0, 32'h1E, 32'h1, 1'b0, 31);
    run_op("slti",  5'd14, 32'h1, 32'h0, 32'hFFFFFFFE, 32'h0, 1'b0, 1);
    run_op("sltui", 5'd15, 32'h1, 32'h0, 32'hFFFFFFFE, 32'h1, 1'b0, 1);
    run_op("andi",  5'd16, 32'h12345678, 32'h0, 32'h0000FFFF, 32'h00005678, 1'b0, 1);
    run_op("xori",  5'd17, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0, 1);
    run_op("ori",   5'd18, 32'h12340000, 32'h0, 32'h00005678, 32'h12345678, 1'b0, 1);
    run_op("ill",   5'd23, 32'hDEADBEEF, 32'h1, 32'h1, 32'h0, 1'b1, 1);
    run_op("ill31", 5'd31, 32'h1, 32'h1, 32'h1, 32'h0, 1'b1, 1);
    run_op("sll0",  5'd2,  32'hCAFEF00D, 32'hFFFFFFE0, 32'h0, 32'hCAFEF00D, 1'b0, 1);

    // backpressure: result holds, in_valid held high waits for IDLE
    alu_op = 5'd7; rs1 = 32'h0F0F0F0F; rs2 = 32'h00FF00FF; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = 5'd0; rs1 = 32'h1; rs2 = 32'h1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.ov",  {31'h0, out_valid}, 32'h1);
      chk("bp.res", result, 32'h0FF00FF0);
      chk("bp.rdy", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.idle", {31'h0, in_ready}, 32'h1);
    chk("bp.ov0",  {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.ov2",  {31'h0, out_valid}, 32'h1);
    chk("bp.res2", result, 32'h2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset in the middle of a long shift
    alu_op = 5'd3; rs1 = 32'hFFFFFFFF; rs2 = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid.busy", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mr.rdy", {31'h0, in_ready}, 32'h1);
    chk("mr.ov",  {31'h0, out_valid}, 32'h0);
    chk("mr.res", result, 32'h0);
    chk("mr.ill", {31'h0, illegal}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      bit ov_seen;
      ov_seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
        if (out_valid) ov_seen = 1'b1;
        @(posedge clk); #1;
      end
      chk("mr.noov", {31'h0, ov_seen}, 32'h0);
    end
    run_op("add2", 5'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
